register_bank_fwd: RTL and testbench

REGISTER_BANK_FWD -- requirements
Module: register_bank_fwd

---
 rtl/regbank_pkg.sv | 15 +
 rtl/register_bank_fwd_sel.sv | 57 +++++
 rtl/register_bank_fwd.sv | 126 ++++++++++++
 tb/tb_register_bank_fwd.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared encodings and defaults for the forwarding register bank.
// The select enum doubles as the manual mux_sel_A/mux_sel_B code.
package regbank_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        SEL_RF = 2'b00,
        SEL_EX = 2'b01,
        SEL_DM = 2'b10,
        SEL_WB = 2'b11
    } fwd_sel_e;

endpackage

// File: rtl/register_bank_fwd_sel.sv
// Per-port operand source selector: explicit mux select or automatic
// EX > DM > WB > register-file priority by destination address compare.
module register_bank_fwd_sel
    import regbank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int AUTO_FWD = 0
) (
    input  logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] ans_dm,
    input  logic [DATA_W-1:0] ans_wb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] RW_ex,
    input  logic [ADDR_W-1:0] RW_dm,
    input  logic [ADDR_W-1:0] RW_wb,
    input  logic              we_ex,
    input  logic              we_dm,
    input  logic              we_wb,
    input  logic [1:0]        mux_sel,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] manual_data;
    logic [DATA_W-1:0] auto_data;
    logic              addr_is_zero;

    assign addr_is_zero = (ZERO_REG != 0) && (addr == '0);

    always_comb begin
        manual_data = rf_data;
        case (fwd_sel_e'(mux_sel))
            SEL_RF: manual_data = rf_data;
            SEL_EX: manual_data = ans_ex;
            SEL_DM: manual_data = ans_dm;
            SEL_WB: manual_data = ans_wb;
        endcase
    end

    // A hard-wired zero register must never pick up an in-flight result.
    always_comb begin
        auto_data = rf_data;
        if (addr_is_zero)
            auto_data = '0;
        else if (we_ex && (RW_ex == addr))
            auto_data = ans_ex;
        else if (we_dm && (RW_dm == addr))
            auto_data = ans_dm;
        else if (we_wb && (RW_wb == addr))
            auto_data = ans_wb;
    end

    assign data = (AUTO_FWD != 0) ? auto_data : manual_data;

endmodule

// File: rtl/register_bank_fwd.sv
// Register file with write-through read and registered, forwarded A/B operands.
// Storage and the output registers live here; source selection is delegated.
module register_bank_fwd
    import regbank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int AUTO_FWD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] ans_dm,
    input  logic [DATA_W-1:0] ans_wb,
    input  logic [DATA_W-1:0] imm,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [ADDR_W-1:0] RW_ex,
    input  logic [ADDR_W-1:0] RW_dm,
    input  logic [ADDR_W-1:0] RW_wb,
    input  logic              we_ex,
    input  logic              we_dm,
    input  logic              we_wb,
    input  logic [1:0]        mux_sel_A,
    input  logic [1:0]        mux_sel_B,
    input  logic              imm_sel,
    input  logic              stall,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] next_b;

    assign wr_en = we_wb && !((ZERO_REG != 0) && (RW_wb == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[RW_wb] <= ans_wb;
        end
    end

    // Write-through: a same-cycle write to the read address bypasses storage.
    always_comb begin
        rf_a = regs[RA];
        if ((ZERO_REG != 0) && (RA == '0))
            rf_a = '0;
        else if (wr_en && (RW_wb == RA))
            rf_a = ans_wb;
    end

    always_comb begin
        rf_b = regs[RB];
        if ((ZERO_REG != 0) && (RB == '0))
            rf_b = '0;
        else if (wr_en && (RW_wb == RB))
            rf_b = ans_wb;
    end

    register_bank_fwd_sel #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .AUTO_FWD(AUTO_FWD)
    ) u_sel_a (
        .rf_data(rf_a),
        .ans_ex (ans_ex),
        .ans_dm (ans_dm),
        .ans_wb (ans_wb),
        .addr   (RA),
        .RW_ex  (RW_ex),
        .RW_dm  (RW_dm),
        .RW_wb  (RW_wb),
        .we_ex  (we_ex),
        .we_dm  (we_dm),
        .we_wb  (we_wb),
        .mux_sel(mux_sel_A),
        .data   (src_a)
    );

    register_bank_fwd_sel #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .AUTO_FWD(AUTO_FWD)
    ) u_sel_b (
        .rf_data(rf_b),
        .ans_ex (ans_ex),
        .ans_dm (ans_dm),
        .ans_wb (ans_wb),
        .addr   (RB),
        .RW_ex  (RW_ex),
        .RW_dm  (RW_dm),
        .RW_wb  (RW_wb),
        .we_ex  (we_ex),
        .we_dm  (we_dm),
        .we_wb  (we_wb),
        .mux_sel(mux_sel_B),
        .data   (src_b)
    );

    assign next_b = imm_sel ? imm : src_b;

    // Stall freezes only the operand registers; the write port keeps running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A <= '0;
            B <= '0;
        end else if (!stall) begin
            A <= src_a;
            B <= next_b;
        end
    end

endmodule

// File: tb/tb_register_bank_fwd.sv
// Randomized and directed bench for register_bank_fwd, driving a manual-select
// and an auto-forwarding instance side by side against an array-based model.
module tb_register_bank_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ans_ex, ans_dm, ans_wb, imm;
    logic [4:0]  RA, RB, RW_ex, RW_dm, RW_wb;
    logic        we_ex, we_dm, we_wb;
    logic [1:0]  mux_sel_A, mux_sel_B;
    logic        imm_sel, stall;
    logic [15:0] a_man, b_man, a_auto, b_auto;

    logic [15:0] m_regs [32];
    logic [15:0] exp_am, exp_bm, exp_aa, exp_ba;
    logic [15:0] held_am, held_aa;
    int          pass_cnt = 0;
    int          check_cnt = 0;

    always #5 clk = ~clk;

    register_bank_fwd #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(1), .AUTO_FWD(0)) dut_man (
        .clk(clk), .rst(rst), .ans_ex(ans_ex), .ans_dm(ans_dm), .ans_wb(ans_wb), .imm(imm),
        .RA(RA), .RB(RB), .RW_ex(RW_ex), .RW_dm(RW_dm), .RW_wb(RW_wb),
        .we_ex(we_ex), .we_dm(we_dm), .we_wb(we_wb), .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B),
        .imm_sel(imm_sel), .stall(stall), .A(a_man), .B(b_man)
    );

    register_bank_fwd #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(1), .AUTO_FWD(1)) dut_auto (
        .clk(clk), .rst(rst), .ans_ex(ans_ex), .ans_dm(ans_dm), .ans_wb(ans_wb), .imm(imm),
        .RA(RA), .RB(RB), .RW_ex(RW_ex), .RW_dm(RW_dm), .RW_wb(RW_wb),
        .we_ex(we_ex), .we_dm(we_dm), .we_wb(we_wb), .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B),
        .imm_sel(imm_sel), .stall(stall), .A(a_auto), .B(b_auto)
    );

    // Architectural value of a register as seen this cycle, including a same-cycle write.
    function automatic logic [15:0] model_rf(input logic [4:0] addr);
        if (addr == 0) return 16'h0000;
        if (we_wb && RW_wb == addr) return ans_wb;
        return m_regs[addr];
    endfunction

    function automatic logic [15:0] model_man(input logic [1:0] sel, input logic [4:0] addr);
        case (sel)
            2'd0:    return model_rf(addr);
            2'd1:    return ans_ex;
            2'd2:    return ans_dm;
            default: return ans_wb;
        endcase
    endfunction

    function automatic logic [15:0] model_auto(input logic [4:0] addr);
        if (addr == 0) return 16'h0000;
        if (we_ex && RW_ex == addr) return ans_ex;
        if (we_dm && RW_dm == addr) return ans_dm;
        if (we_wb && RW_wb == addr) return ans_wb;
        return model_rf(addr);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
        exp_am = 0; exp_bm = 0; exp_aa = 0; exp_ba = 0;
    endtask

    task automatic idle_inputs();
        ans_ex = 0; ans_dm = 0; ans_wb = 0; imm = 0;
        RA = 0; RB = 0; RW_ex = 0; RW_dm = 0; RW_wb = 0;
        we_ex = 0; we_dm = 0; we_wb = 0;
        mux_sel_A = 0; mux_sel_B = 0; imm_sel = 0; stall = 0;
    endtask

    // Advance one clock, updating the model from the inputs that were stable before the edge.
    task automatic cycle();
        logic [15:0] n_am, n_bm, n_aa, n_ba;
        n_am = model_man(mux_sel_A, RA);
        n_bm = imm_sel ? imm : model_man(mux_sel_B, RB);
        n_aa = model_auto(RA);
        n_ba = imm_sel ? imm : model_auto(RB);
        @(posedge clk);
        if (!rst) begin
            if (!stall) begin
                exp_am = n_am; exp_bm = n_bm; exp_aa = n_aa; exp_ba = n_ba;
            end
            if (we_wb && RW_wb != 0) m_regs[RW_wb] = ans_wb;
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        clear_model();
        rst = 1'b1;
        #2;
        check_cnt++; if (a_man !== 16'h0) $display("[TB] FAIL reset_a_man: got %h want 0000", a_man); else pass_cnt++;
        check_cnt++; if (b_man !== 16'h0) $display("[TB] FAIL reset_b_man: got %h want 0000", b_man); else pass_cnt++;
        check_cnt++; if (a_auto !== 16'h0) $display("[TB] FAIL reset_a_auto: got %h want 0000", a_auto); else pass_cnt++;
        check_cnt++; if (b_auto !== 16'h0) $display("[TB] FAIL reset_b_auto: got %h want 0000", b_auto); else pass_cnt++;
        we_wb = 1; RW_wb = 9; ans_wb = 16'hAAAA; mux_sel_A = 2'd3; RA = 9;
        cycle();
        check_cnt++; if (a_man !== 16'h0) $display("[TB] FAIL reset_hold_a: got %h want 0000", a_man); else pass_cnt++;
        rst = 1'b0;
        idle_inputs();
        RA = 9;
        cycle();
        check_cnt++; if (a_man !== 16'h0) $display("[TB] FAIL reset_blocked_write: got %h want 0000", a_man); else pass_cnt++;
    endtask

    task automatic test_manual_fwd();
        idle_inputs();
        ans_ex = 16'hC000; ans_dm = 16'hD000; ans_wb = 16'hE000;
        mux_sel_A = 2'b10; mux_sel_B = 2'b01;
        cycle();
        check_cnt++; if (a_man !== 16'hD000) $display("[TB] FAIL manual_a_dm: got %h want D000", a_man); else pass_cnt++;
        check_cnt++; if (b_man !== 16'hC000) $display("[TB] FAIL manual_b_ex: got %h want C000", b_man); else pass_cnt++;
        mux_sel_A = 2'b11;
        cycle();
        check_cnt++; if (a_man !== 16'hE000) $display("[TB] FAIL manual_a_wb: got %h want E000", a_man); else pass_cnt++;
    endtask

    task automatic test_write_bypass();
        idle_inputs();
        we_wb = 1; RW_wb = 7; ans_wb = 16'h1234; RA = 7; mux_sel_A = 2'b00;
        cycle();
        check_cnt++; if (a_man !== 16'h1234) $display("[TB] FAIL bypass_a_man: got %h want 1234", a_man); else pass_cnt++;
        check_cnt++; if (a_auto !== 16'h1234) $display("[TB] FAIL bypass_a_auto: got %h want 1234", a_auto); else pass_cnt++;
        we_wb = 0; ans_wb = 16'h0000;
        cycle();
        check_cnt++; if (a_man !== 16'h1234) $display("[TB] FAIL stored_a_man: got %h want 1234", a_man); else pass_cnt++;
        check_cnt++; if (a_auto !== 16'h1234) $display("[TB] FAIL stored_a_auto: got %h want 1234", a_auto); else pass_cnt++;
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        we_wb = 1; RW_wb = 0; ans_wb = 16'h5555; RA = 0;
        cycle();
        check_cnt++; if (a_man !== 16'h0) $display("[TB] FAIL zero_wt_man: got %h want 0000", a_man); else pass_cnt++;
        check_cnt++; if (a_auto !== 16'h0) $display("[TB] FAIL zero_wt_auto: got %h want 0000", a_auto); else pass_cnt++;
        we_wb = 0;
        cycle();
        check_cnt++; if (a_man !== 16'h0) $display("[TB] FAIL zero_read: got %h want 0000", a_man); else pass_cnt++;
        we_ex = 1; RW_ex = 0; ans_ex = 16'hC000;
        cycle();
        check_cnt++; if (a_auto !== 16'h0) $display("[TB] FAIL zero_no_fwd: got %h want 0000", a_auto); else pass_cnt++;
    endtask

    task automatic test_auto_priority();
        idle_inputs();
        RA = 5; RW_ex = 5; RW_dm = 5; RW_wb = 5;
        we_ex = 1; we_dm = 1; we_wb = 1;
        ans_ex = 16'hC000; ans_dm = 16'hD000; ans_wb = 16'hE000;
        cycle();
        check_cnt++; if (a_auto !== 16'hC000) $display("[TB] FAIL prio_ex: got %h want C000", a_auto); else pass_cnt++;
        we_ex = 0;
        cycle();
        check_cnt++; if (a_auto !== 16'hD000) $display("[TB] FAIL prio_dm: got %h want D000", a_auto); else pass_cnt++;
        we_dm = 0;
        cycle();
        check_cnt++; if (a_auto !== 16'hE000) $display("[TB] FAIL prio_wb: got %h want E000", a_auto); else pass_cnt++;
    endtask

    task automatic test_imm_stall();
        idle_inputs();
        RA = 5; imm_sel = 1; imm = 16'hFFFF; mux_sel_B = 2'b01; ans_ex = 16'h0BAD;
        cycle();
        check_cnt++; if (b_man !== 16'hFFFF) $display("[TB] FAIL imm_b_man: got %h want FFFF", b_man); else pass_cnt++;
        check_cnt++; if (b_auto !== 16'hFFFF) $display("[TB] FAIL imm_b_auto: got %h want FFFF", b_auto); else pass_cnt++;
        check_cnt++; if (a_auto !== 16'hE000) $display("[TB] FAIL imm_a_unaffected: got %h want E000", a_auto); else pass_cnt++;
        held_am = exp_am; held_aa = exp_aa;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            ans_ex = 16'($urandom); ans_dm = 16'($urandom); imm = 16'($urandom);
            RA = 5'($urandom_range(1, 31)); RB = 5'($urandom_range(1, 31));
            mux_sel_A = 2'($urandom); mux_sel_B = 2'($urandom); imm_sel = 1'($urandom);
            we_wb = (i == 0); RW_wb = 3; ans_wb = 16'h3333;
            cycle();
            check_cnt++; if (a_man !== held_am) $display("[TB] FAIL stall_a_man: got %h want %h", a_man, held_am); else pass_cnt++;
            check_cnt++; if (b_man !== 16'hFFFF) $display("[TB] FAIL stall_b_man: got %h want FFFF", b_man); else pass_cnt++;
            check_cnt++; if (a_auto !== held_aa) $display("[TB] FAIL stall_a_auto: got %h want %h", a_auto, held_aa); else pass_cnt++;
            check_cnt++; if (b_auto !== 16'hFFFF) $display("[TB] FAIL stall_b_auto: got %h want FFFF", b_auto); else pass_cnt++;
        end
        idle_inputs();
        RA = 3; RB = 3;
        cycle();
        check_cnt++; if (a_man !== 16'h3333) $display("[TB] FAIL stall_write_a: got %h want 3333", a_man); else pass_cnt++;
        check_cnt++; if (b_auto !== 16'h3333) $display("[TB] FAIL stall_write_b: got %h want 3333", b_auto); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            ans_ex = 16'($urandom); ans_dm = 16'($urandom); ans_wb = 16'($urandom); imm = 16'($urandom);
            RA = 5'($urandom_range(0, 7)); RB = 5'($urandom_range(0, 7));
            RW_ex = 5'($urandom_range(0, 7)); RW_dm = 5'($urandom_range(0, 7)); RW_wb = 5'($urandom_range(0, 7));
            we_ex = 1'($urandom); we_dm = 1'($urandom); we_wb = 1'($urandom);
            mux_sel_A = 2'($urandom); mux_sel_B = 2'($urandom);
            imm_sel = ($urandom_range(0, 3) == 0); stall = ($urandom_range(0, 4) == 0);
            cycle();
            check_cnt++; if (a_man !== exp_am) $display("[TB] FAIL rand_a_man #%0d: got %h want %h", n, a_man, exp_am); else pass_cnt++;
            check_cnt++; if (b_man !== exp_bm) $display("[TB] FAIL rand_b_man #%0d: got %h want %h", n, b_man, exp_bm); else pass_cnt++;
            check_cnt++; if (a_auto !== exp_aa) $display("[TB] FAIL rand_a_auto #%0d: got %h want %h", n, a_auto, exp_aa); else pass_cnt++;
            check_cnt++; if (b_auto !== exp_ba) $display("[TB] FAIL rand_b_auto #%0d: got %h want %h", n, b_auto, exp_ba); else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        RA = 3; RB = 7;
        cycle();
        we_wb = 1; RW_wb = 4; ans_wb = 16'hBEEF;
        #3;
        rst = 1'b1;
        #1;
        check_cnt++; if (a_man !== 16'h0) $display("[TB] FAIL async_a_man: got %h want 0000", a_man); else pass_cnt++;
        check_cnt++; if (b_man !== 16'h0) $display("[TB] FAIL async_b_man: got %h want 0000", b_man); else pass_cnt++;
        check_cnt++; if (a_auto !== 16'h0) $display("[TB] FAIL async_a_auto: got %h want 0000", a_auto); else pass_cnt++;
        check_cnt++; if (b_auto !== 16'h0) $display("[TB] FAIL async_b_auto: got %h want 0000", b_auto); else pass_cnt++;
        clear_model();
        cycle();
        check_cnt++; if (a_man !== 16'h0) $display("[TB] FAIL async_hold_a: got %h want 0000", a_man); else pass_cnt++;
        #2;
        rst = 1'b0;
        idle_inputs();
        for (int addr = 0; addr < 32; addr++) begin
            RA = 5'(addr); RB = 5'(addr);
            cycle();
            check_cnt++; if (a_man !== 16'h0) $display("[TB] FAIL cleared_a r%0d: got %h want 0000", addr, a_man); else pass_cnt++;
            check_cnt++; if (b_auto !== 16'h0) $display("[TB] FAIL cleared_b r%0d: got %h want 0000", addr, b_auto); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_manual_fwd();
        test_write_bypass();
        test_zero_reg();
        test_auto_priority();
        test_imm_stall();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
